// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with bus lock and anti-starvation lock
// timeout. It shares one fabric port among m_w masters.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   bus_req/bus_lock   per-master request and lock (hold grant while requesting)
//   bus_grant          registered one-hot grant (or zero)
//   addr_m/wd_m/we_m/size_m   per-master transfer fields
//   rd_m               fabric read data broadcast to every master
//   addr_f/wd_f/we_f/size_f   granted master's fields, zero when idle
//   rd_f               fabric read data

// Per-master lane: forwards the master's fields only while it holds the grant.
// The top ORs all lanes together, so the one-hot grant selects the owner.
module rr_lock_arbiter_lane (
  input  logic        gnt,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [1:0]  size,
  output logic [31:0] addr_g,
  output logic [31:0] wd_g,
  output logic        we_g,
  output logic [1:0]  size_g
);
  assign addr_g = gnt ? addr : '0;
  assign wd_g   = gnt ? wd   : '0;
  assign we_g   = gnt & we;
  assign size_g = gnt ? size : '0;
endmodule

module rr_lock_arbiter #(
  parameter int m_w      = 2,
  parameter int max_lock = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [m_w-1:0]        bus_req,
  input  logic [m_w-1:0]        bus_lock,
  output logic [m_w-1:0]        bus_grant,
  input  logic [m_w-1:0][31:0]  addr_m,
  input  logic [m_w-1:0][31:0]  wd_m,
  input  logic [m_w-1:0]        we_m,
  input  logic [m_w-1:0][1:0]   size_m,
  output logic [m_w-1:0][31:0]  rd_m,
  output logic [31:0]           addr_f,
  output logic [31:0]           wd_f,
  output logic                  we_f,
  output logic [1:0]            size_f,
  input  logic [31:0]           rd_f
);
  localparam int OW  = (m_w > 1) ? $clog2(m_w) : 1;
  localparam int LCW = (max_lock > 1) ? $clog2(max_lock) : 1;
  // The counter only needs to reach max_lock-1. With max_lock=0 the value is
  // never compared against, so any constant will do.
  localparam logic [LCW-1:0] CNT_MAX = (max_lock > 0) ? LCW'(max_lock - 1) : '1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state, state_nx;
  logic [OW-1:0]  owner, owner_nx, last, last_nx;
  logic [LCW-1:0] lock_cnt, lock_cnt_nx;
  logic [OW-1:0]  base, pick, cand;
  logic           found, any_req, lock_hit, keep;
  logic [m_w-1:0] own_oh, grant_nx;

  assign any_req = |bus_req;
  assign own_oh  = m_w'(1) << owner;

  // Round-robin pick. The search starts just after the previous winner, so
  // that winner has the lowest priority. In OWN, last always equals owner.
  always_comb begin
    base  = (state == OWN) ? owner : last;
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= m_w; k++) begin
      cand = OW'((int'(base) + k) % m_w);
      if (!found && bus_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A lock is broken only when it has run its full budget and someone else
  // is waiting. If nobody else is waiting, the lock holder keeps the bus.
  assign lock_hit = (max_lock != 0) && (lock_cnt == CNT_MAX) &&
                    ((bus_req & ~own_oh) != '0);
  assign keep     = bus_req[owner] & bus_lock[owner] & ~lock_hit;

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    lock_cnt_nx = lock_cnt;
    if (state == IDLE) begin
      if (any_req) begin
        state_nx    = OWN;
        owner_nx    = pick;
        last_nx     = pick;
        lock_cnt_nx = '0;
      end
    end else if (keep) begin
      if (max_lock != 0 && lock_cnt != CNT_MAX) lock_cnt_nx = lock_cnt + 1'b1;
    end else if (any_req) begin
      // Hand over directly. No idle cycle between owners.
      owner_nx    = pick;
      last_nx     = pick;
      lock_cnt_nx = '0;
    end else begin
      state_nx    = IDLE;
      lock_cnt_nx = '0;
    end
    grant_nx = (state_nx == OWN) ? (m_w'(1) << owner_nx) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= OW'(m_w - 1);
      lock_cnt  <= '0;
      bus_grant <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      lock_cnt  <= lock_cnt_nx;
      bus_grant <= grant_nx;
    end
  end

  // Fabric mux. Each lane gates its master with its own grant bit. Reset
  // clears bus_grant asynchronously, so the fabric outputs drop with it.
  logic [m_w-1:0][31:0] addr_g, wd_g;
  logic [m_w-1:0]       we_g;
  logic [m_w-1:0][1:0]  size_g;

  for (genvar i = 0; i < m_w; i++) begin : g_lane
    rr_lock_arbiter_lane u_lane (
      .gnt    (bus_grant[i]),
      .addr   (addr_m[i]),
      .wd     (wd_m[i]),
      .we     (we_m[i]),
      .size   (size_m[i]),
      .addr_g (addr_g[i]),
      .wd_g   (wd_g[i]),
      .we_g   (we_g[i]),
      .size_g (size_g[i])
    );
    assign rd_m[i] = rd_f;
  end

  always_comb begin
    addr_f = '0;
    wd_f   = '0;
    we_f   = 1'b0;
    size_f = '0;
    for (int i = 0; i < m_w; i++) begin
      addr_f = addr_f | addr_g[i];
      wd_f   = wd_f   | wd_g[i];
      we_f   = we_f   | we_g[i];
      size_f = size_f | size_g[i];
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter. It uses two instances: dut
// (max_lock=16) and dut4 (max_lock=4). Both are driven from the same master
// inputs. A vector table covers single-cycle arbitration and the fabric mux.
// Hand-written sequences cover alternation from reset, long locks, forced
// release and asynchronous reset.
module tb_rr_lock_arbiter;
  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        bus_req, bus_lock, we_m;
  logic [1:0][31:0]  addr_m, wd_m;
  logic [1:0][1:0]   size_m;
  logic [31:0]       rd_f;

  logic [1:0]        gnt, gnt4;
  logic [1:0][31:0]  rd_m, rd_m4;
  logic [31:0]       addr_f, wd_f, addr_f4, wd_f4;
  logic              we_f, we_f4;
  logic [1:0]        size_f, size_f4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.m_w(2), .max_lock(16)) dut (
    .clk(clk), .rstn(rstn), .bus_req(bus_req), .bus_lock(bus_lock),
    .bus_grant(gnt), .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m),
    .size_m(size_m), .rd_m(rd_m), .addr_f(addr_f), .wd_f(wd_f),
    .we_f(we_f), .size_f(size_f), .rd_f(rd_f)
  );

  rr_lock_arbiter #(.m_w(2), .max_lock(4)) dut4 (
    .clk(clk), .rstn(rstn), .bus_req(bus_req), .bus_lock(bus_lock),
    .bus_grant(gnt4), .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m),
    .size_m(size_m), .rd_m(rd_m4), .addr_f(addr_f4), .wd_f(wd_f4),
    .we_f(we_f4), .size_f(size_f4), .rd_f(rd_f)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we_f;
    logic [1:0]  size;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
  endtask

  localparam logic [31:0] A0 = 32'h0000_0010, D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] A1 = 32'h0000_0200, D1 = 32'hA5A5_0001;

  initial begin
    rstn     = 1'b1;
    bus_req  = '0;
    bus_lock = '0;
    we_m     = 2'b01;
    addr_m[0] = A0;  wd_m[0] = D0;  size_m[0] = 2'b10;
    addr_m[1] = A1;  wd_m[1] = D1;  size_m[1] = 2'b01;
    rd_f     = '0;

    //           req    lock   we     gnt    addr  wd    we_f  size
    tbl[0]  = '{2'b00, 2'b00, 2'b01, 2'b00, 0,    0,    1'b0, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 2'b01, A0,   D0,   1'b1, 2'b10};
    tbl[2]  = '{2'b00, 2'b00, 2'b01, 2'b00, 0,    0,    1'b0, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 2'b01, 2'b10, A1,   D1,   1'b0, 2'b01};
    tbl[4]  = '{2'b11, 2'b00, 2'b01, 2'b01, A0,   D0,   1'b1, 2'b10};
    tbl[5]  = '{2'b11, 2'b00, 2'b01, 2'b10, A1,   D1,   1'b0, 2'b01};
    tbl[6]  = '{2'b10, 2'b10, 2'b01, 2'b10, A1,   D1,   1'b0, 2'b01};
    tbl[7]  = '{2'b11, 2'b10, 2'b01, 2'b10, A1,   D1,   1'b0, 2'b01};
    tbl[8]  = '{2'b11, 2'b00, 2'b01, 2'b01, A0,   D0,   1'b1, 2'b10};
    tbl[9]  = '{2'b01, 2'b01, 2'b01, 2'b01, A0,   D0,   1'b1, 2'b10};
    tbl[10] = '{2'b10, 2'b01, 2'b01, 2'b10, A1,   D1,   1'b0, 2'b01};
    tbl[11] = '{2'b10, 2'b00, 2'b11, 2'b10, A1,   D1,   1'b1, 2'b01};
    tbl[12] = '{2'b00, 2'b00, 2'b01, 2'b00, 0,    0,    1'b0, 2'b00};

    // Asynchronous reset state, sampled with no clock edge in between.
    #2 rstn = 1'b0;
    #1;
    check("rst_grant",  32'(gnt),    0);
    check("rst_addr_f", addr_f,      0);
    check("rst_wd_f",   wd_f,        0);
    check("rst_we_f",   32'(we_f),   0);
    check("rst_size_f", 32'(size_f), 0);
    step();
    rstn = 1'b1;

    // Table vectors. Inputs are applied, one edge is taken, then the grant
    // and the fabric mux are checked.
    for (int v = 0; v < 13; v++) begin
      bus_req  = tbl[v].req;
      bus_lock = tbl[v].lock;
      we_m     = tbl[v].we;
      step();
      check($sformatf("v%0d_grant", v), 32'(gnt),    32'(tbl[v].gnt));
      check($sformatf("v%0d_addr",  v), addr_f,      tbl[v].addr);
      check($sformatf("v%0d_wd",    v), wd_f,        tbl[v].wd);
      check($sformatf("v%0d_we",    v), 32'(we_f),   32'(tbl[v].we_f));
      check($sformatf("v%0d_size",  v), 32'(size_f), 32'(tbl[v].size));
    end
    we_m = 2'b01;

    // Idle bus: read data still reaches every master.
    bus_req = '0; bus_lock = '0;
    rd_f = 32'h1234_5678;
    step();
    check("idle_grant", 32'(gnt),  0);
    check("idle_we_f",  32'(we_f), 0);
    check("idle_addr",  addr_f,    0);
    check("rd_m0",      rd_m[0],   32'h1234_5678);
    check("rd_m1",      rd_m[1],   32'h1234_5678);
    rd_f = 32'hCAFE_0042;
    #1;
    check("rd_m1_b",    rd_m[1],   32'hCAFE_0042);

    // Both masters request from reset: master 0 wins first, then they alternate.
    do_reset();
    bus_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("alt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Master 1 owns the bus now. Its lock keeps the grant 5 cycles in total,
    // then master 0 gets the bus on the edge after the lock drops.
    bus_lock = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("lock5_%0d", i), 32'(gnt), 32'h2);
    end
    bus_lock = 2'b00;
    step();
    check("lock5_rel", 32'(gnt), 32'h1);

    // max_lock=4 instance: master 1 locks indefinitely. Master 0 starts
    // requesting at cycle 2. Master 1 keeps the grant exactly 4 cycles, then
    // master 0 gets 1 cycle, then master 1 takes the bus back.
    do_reset();
    bus_req = 2'b10; bus_lock = 2'b10;
    begin
      logic [1:0] exp4 [10];
      exp4 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
               2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      for (int i = 0; i < 10; i++) begin
        if (i == 2) bus_req = 2'b11;
        step();
        check($sformatf("ml4_%0d", i), 32'(gnt4), 32'(exp4[i]));
      end
    end
    // The same lock pattern on the max_lock=16 instance must not be broken
    // this early.
    check("ml16_hold", 32'(gnt), 32'h2);

    // Reset in the middle of a locked write by master 1.
    do_reset();
    bus_req = 2'b10; bus_lock = 2'b10; we_m = 2'b10;
    step();
    check("mid_grant", 32'(gnt),  32'h2);
    check("mid_we_f",  32'(we_f), 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_grant", 32'(gnt),  0);
    check("arst_we_f",  32'(we_f), 0);
    check("arst_addr",  addr_f,    0);
    step();
    rstn = 1'b1;
    bus_req = 2'b11; bus_lock = 2'b00;
    step();
    check("post_rst_first", 32'(gnt), 32'h1);
    step();
    check("post_rst_second", 32'(gnt), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
